matvec_col_stream: RTL
======================

// Module: matvec_col_stream
// PURPOSE
//  Streaming, column-serial matrix-vector multiplier: y = K*x, with K of size R x C.
//  Each input beat carries one element x[c] and the matching column K[:,c].
//  R signed MAC lanes accumulate across C beats, then present y on an output stream.
//  Low-area counterpart of the fully parallel row/adder-tree matvec, for datapaths that receive x serially.
// PARAMETERS
//  R      8  rows of K = number of MAC lanes = output elements
//  C      8  columns of K = beats per vector (C >= 1, need not be a power of 2)
//  W_X    8  signed width of x elements
//  W_K    8  signed width of K elements
//  derived (localparam): W_M = W_X+W_K; DEPTH = $clog2(C); W_Y = W_M+DEPTH
// PORTS
//  clk      in   1           clock, rising edge
//  rstn     in   1           asynchronous active-low reset
//  s_valid  in   1           input beat valid
//  s_ready  out  1           input beat ready
//  s_x      in   W_X         x[c], signed
//  s_k      in   [R][W_K]    column K[0..R-1][c], signed
//  m_valid  out  1           result valid
//  m_ready  in   1           result ready
//  m_y      out  [R][W_Y]    y[0..R-1], signed
// BEHAVIOUR
//  - Handshake: a transfer occurs on a rising edge where valid & ready are both 1. s_x/s_k are sampled only on an input transfer.
//    m_valid, once high, holds until an output transfer. m_y is stable while m_valid = 1.
//  - FSM with 3 states:
//      ACC:   s_ready = 1.
//      FLUSH: s_ready = 0, m_valid = 0.
//      OUT:   s_ready = 0, m_valid = 1.
//    s_ready is (state==ACC), decoded from the state register.
//  - Transitions:
//      ACC -> FLUSH on the input transfer with col == C-1.
//      FLUSH -> OUT after exactly 1 cycle.
//      OUT -> ACC on the output transfer.
//  - Column counter col, range 0..C-1: increments on each input transfer; wraps to 0 on the transfer at C-1.
//  - Stage 1 (on input transfer): p[r] <= s_k[r]*s_x, signed, W_M bits. Flags first = (col==0) and pv = 1 are registered alongside.
//  - Stage 2 (when pv): acc[r] <= first ? sext(p[r]) : acc[r] + sext(p[r]), W_Y bits.
//  - m_y = acc.
//  - Latency: m_valid rises 2 cycles after the edge of the last column's transfer.
//    Minimum period per vector = C+2 cycles + output-stall cycles.
//  - Width: W_Y holds C worst-case products, e.g. (-2^(W_X-1))*(-2^(W_K-1))*C, so no overflow; no saturation logic.
//  - C == 1: every beat is both first and last; col stays 0.
//  - Input bubbles (s_valid low mid-vector): no effect on the result; col and acc hold.
//  - Back-pressure: in FLUSH/OUT no input is accepted. Upstream holds s_valid/data per protocol.
//  - Reset (including mid-vector):
//      state = ACC, col = 0, pv = 0, p = 0, acc = 0.
//      m_valid = 0, m_y = 0, s_ready = 1.
//    A partial vector is discarded. The first transfer after reset is column 0.
// STRUCTURE
//  - matvec_pkg: typedef enum logic [1:0] {ACC, FLUSH, OUT} mv_state_e.
//  - matvec_pkg: function matvec_wy(wx, wk, c) returning wx+wk+$clog2(c).
//    The parallel matvec uses the same rule, so output widths match.
//  - Sub-module matvec_mac_lane: holds p and acc for one row, with inputs first/pv/en. Instantiated R times by a generate loop.
//  - Top level holds only the FSM, col counter and stream handshake.
// TESTING  (R=2, C=4, W_X=W_K=8 unless noted; m_ready=1 unless noted)
//  1. K rows {1,2,3,4} and {-1,-1,-1,-1}, x={1,1,1,1} over 4 consecutive beats
//     -> m_y={10,-4}; m_valid high 2 cycles after the 4th transfer; s_ready=0 for 2 cycles.
//  2. R=1, C=8, all k=-128, all x=-128
//     -> m_y=131072 (W_Y=19), no wrap.
//     Mixed signs: k=127, x=-128 -> m_y=-130048.
//  3. Hold m_ready=0 for 5 cycles after m_valid
//     -> m_valid and m_y stable; s_ready=0 with s_valid=1, no beats lost.
//     Release -> one output transfer, s_ready=1 the next cycle.
//  4. Same data as test 1 with s_valid low for 1-3 random cycles between beats
//     -> identical m_y={10,-4}.
//  5. Assert rstn low after 2 beats of a vector, then send a full new vector (test 1 data)
//     -> all outputs 0 during reset; result {10,-4}, no residue from the aborted vector.
//  6. 200 random back-to-back vectors (R=8, C=5, random m_ready) checked against a golden model
//     -> all match; next vector's first transfer no earlier than the cycle after the output transfer.

Source files
------------

// File: rtl/matvec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : matvec_pkg
// Description : Shared types and width rule for the matrix-vector multipliers.
//               mv_state_e    - column-serial controller states
//               matvec_wy()   - result width: wx + wk + clog2(c), shared with
//                               the parallel matvec so the two output widths
//                               are interchangeable.
// Revision    : 1.0 - initial release
// ============================================================================
package matvec_pkg;

  typedef enum logic [1:0] {
    ACC   = 2'd0,
    FLUSH = 2'd1,
    OUT   = 2'd2
  } mv_state_e;

  // Enough headroom for c worst-case products (-2^(wx-1) * -2^(wk-1)).
  function automatic int matvec_wy(input int wx, input int wk, input int c);
    return wx + wk + $clog2(c);
  endfunction

endpackage
`default_nettype wire

// File: rtl/matvec_mac_lane.sv
`default_nettype none
// ============================================================================
// Module      : matvec_mac_lane
// Description : One signed multiply-accumulate lane (one row of K).
//               Stage 1 registers the product k*x on an input transfer,
//               stage 2 folds the registered product into the accumulator.
// Ports       : clk      - clock, rising edge
//               rstn     - asynchronous active-low reset
//               en_i     - input transfer: capture k_i*x_i
//               first_i  - registered product belongs to column 0
//               pv_i     - registered product is valid this cycle
//               x_i      - x[c], signed W_X
//               k_i      - K[r][c], signed W_K
//               y_o      - accumulator, signed W_Y
// Revision    : 1.0 - initial release
// ============================================================================
module matvec_mac_lane
  import matvec_pkg::*;
#(
  parameter int W_X = 8,
  parameter int W_K = 8,
  parameter int W_Y = 19
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  en_i,
  input  logic                  first_i,
  input  logic                  pv_i,
  input  logic signed [W_X-1:0] x_i,
  input  logic signed [W_K-1:0] k_i,
  output logic signed [W_Y-1:0] y_o
);

  localparam int W_M = W_X + W_K;

  logic signed [W_M-1:0] p_q, p_d;
  logic signed [W_Y-1:0] acc_q, acc_d;

  always_comb begin
    p_d   = p_q;
    acc_d = acc_q;
    if (en_i) begin
      p_d = W_M'(x_i) * W_M'(k_i);
    end
    // Column 0 restarts the sum so no state carries between vectors.
    if (pv_i) begin
      acc_d = first_i ? W_Y'(p_q) : acc_q + W_Y'(p_q);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      p_q   <= '0;
      acc_q <= '0;
    end else begin
      p_q   <= p_d;
      acc_q <= acc_d;
    end
  end

  assign y_o = acc_q;

endmodule
`default_nettype wire

// File: rtl/matvec_col_stream.sv
`default_nettype none
// ============================================================================
// Module      : matvec_col_stream
// Description : Streaming column-serial matrix-vector multiplier y = K*x.
//               Each input beat carries x[c] and column K[:,c]; R MAC lanes
//               accumulate over C beats, then y is offered on the output
//               stream. Holds only the FSM, column counter and handshake.
// Ports       : clk      - clock, rising edge
//               rstn     - asynchronous active-low reset
//               s_valid  - input beat valid
//               s_ready  - input beat ready (state == ACC)
//               s_x      - x[c], signed W_X
//               s_k      - column K[0..R-1][c], signed W_K each
//               m_valid  - result valid (state == OUT)
//               m_ready  - result ready
//               m_y      - y[0..R-1], signed W_Y each
// Revision    : 1.0 - initial release
// ============================================================================
module matvec_col_stream
  import matvec_pkg::*;
#(
  parameter  int R     = 8,
  parameter  int C     = 8,
  parameter  int W_X   = 8,
  parameter  int W_K   = 8,
  localparam int DEPTH = $clog2(C),
  localparam int W_Y   = matvec_wy(W_X, W_K, C)
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [W_X-1:0]            s_x,
  input  logic [R-1:0][W_K-1:0]     s_k,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [R-1:0][W_Y-1:0]     m_y
);

  // C == 1 still needs a 1-bit counter; it simply never leaves 0.
  localparam int              W_COL    = (DEPTH > 0) ? DEPTH : 1;
  localparam logic [W_COL-1:0] COL_LAST = W_COL'(C - 1);

  mv_state_e        state_q, state_d;
  logic [W_COL-1:0] col_q, col_d;
  logic             first_q, first_d;
  logic             pv_q, pv_d;
  logic             in_xfer;
  logic             out_xfer;
  logic             col_last;

  assign s_ready  = (state_q == ACC);
  assign m_valid  = (state_q == OUT);
  assign in_xfer  = s_valid & s_ready;
  assign out_xfer = m_valid & m_ready;
  assign col_last = (col_q == COL_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACC:     if (in_xfer && col_last) state_d = FLUSH;
      // One cycle lets the last product drain into the accumulators.
      FLUSH:   state_d = OUT;
      OUT:     if (out_xfer) state_d = ACC;
      default: state_d = ACC;
    endcase
  end

  always_comb begin
    col_d   = col_q;
    first_d = first_q;
    pv_d    = in_xfer;
    if (in_xfer) begin
      col_d   = col_last ? '0 : col_q + W_COL'(1);
      first_d = (col_q == '0);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ACC;
      col_q   <= '0;
      first_q <= 1'b0;
      pv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      first_q <= first_d;
      pv_q    <= pv_d;
    end
  end

  for (genvar r = 0; r < R; r++) begin : g_lane
    matvec_mac_lane #(
      .W_X (W_X),
      .W_K (W_K),
      .W_Y (W_Y)
    ) u_lane (
      .clk     (clk),
      .rstn    (rstn),
      .en_i    (in_xfer),
      .first_i (first_q),
      .pv_i    (pv_q),
      .x_i     (s_x),
      .k_i     (s_k[r]),
      .y_o     (m_y[r])
    );
  end

endmodule
`default_nettype wire
